// File: rtl/johnson_step_controller_pkg.sv
// Shared types and constants for the Johnson step controller.
// FSM encoding, direction codes and the home phase pattern.
package johnson_step_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;

  function automatic logic [31:0] home_word(
    input int unsigned w
  );
    return 32'h1 << (w - 1);
  endfunction

endpackage

// File: rtl/johnson_phase_reg.sv
// Twisted-ring phase register with direction, enable,
// legality check and home reload on an illegal pattern.
module johnson_phase_reg
  import johnson_step_controller_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_dir,
  output logic [WIDTH-1:0] o_q,
  output logic             o_illegal
);

  localparam logic [WIDTH-1:0] HOME =
    WIDTH'(home_word(WIDTH));

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_nxt;
  logic             w_illegal;
  int unsigned      w_tr;

  // Legal codes have at most one boundary between ones and zeros.
  always_comb begin
    w_tr = 0;
    for (int i = 0; i < WIDTH - 1; i++) begin
      if (r_q[i] != r_q[i+1]) w_tr = w_tr + 1;
    end
    w_illegal = (w_tr > 1);
  end

  always_comb begin
    w_nxt = HOME;
    if (!w_illegal) begin
      unique case (i_dir)
        DIR_FWD: w_nxt = {~r_q[0], r_q[WIDTH-1:1]};
        DIR_REV: w_nxt = {r_q[WIDTH-2:0], ~r_q[WIDTH-1]};
        default: w_nxt = HOME;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_q <= HOME;
    end else if (i_en) begin
      r_q <= w_nxt;
    end
  end

  assign o_q       = r_q;
  assign o_illegal = w_illegal;

endmodule

// File: rtl/johnson_step_controller.sv
// Command sequencer: step-period divider, remaining-step
// counter and IDLE/RUN/DONE control over the phase register.
module johnson_step_controller
  import johnson_step_controller_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic             cmd_dir,
  input  logic [DIV_W-1:0] cmd_period,
  input  logic             abort,
  output logic [WIDTH-1:0] phase,
  output logic             step_pulse,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             err
);

  state_t           r_st;
  state_t           w_nst;
  logic             r_dir;
  logic [DIV_W-1:0] r_per;
  logic [DIV_W-1:0] r_div;
  logic [CNT_W-1:0] r_rem;
  logic             r_pulse;
  logic             r_abt;
  logic             r_err;
  logic             w_acc;
  logic             w_step;
  logic             w_illegal;

  always_comb begin
    w_nst  = r_st;
    w_acc  = 1'b0;
    w_step = 1'b0;
    unique case (r_st)
      ST_IDLE: begin
        if (cmd_valid) begin
          w_acc = 1'b1;
          w_nst = (cmd_steps == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        // Abort wins over a step due on the same edge.
        if (abort) begin
          w_nst = ST_DONE;
        end else if (r_div == '0) begin
          w_step = 1'b1;
          if (r_rem <= CNT_W'(1)) w_nst = ST_DONE;
        end
      end
      ST_DONE: w_nst = ST_IDLE;
      default: w_nst = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_st    <= ST_IDLE;
      r_dir   <= DIR_FWD;
      r_per   <= '0;
      r_div   <= '0;
      r_rem   <= '0;
      r_pulse <= 1'b0;
      r_abt   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_st    <= w_nst;
      r_pulse <= w_step;
      if (w_acc) begin
        r_dir <= cmd_dir;
        r_per <= cmd_period;
        r_div <= cmd_period;
        r_rem <= cmd_steps;
        r_abt <= 1'b0;
        r_err <= 1'b0;
      end else if (r_st == ST_RUN && abort) begin
        r_abt <= 1'b1;
      end else if (w_step) begin
        r_div <= r_per;
        if (r_rem != '0) r_rem <= r_rem - CNT_W'(1);
      end else if (r_st == ST_RUN) begin
        r_div <= r_div - DIV_W'(1);
      end
      if (w_step && w_illegal) r_err <= 1'b1;
    end
  end

  johnson_phase_reg #(
    .WIDTH(WIDTH)
  ) u_ph (
    .clk      (clk),
    .rst      (rst),
    .i_en     (w_step),
    .i_dir    (r_dir),
    .o_q      (phase),
    .o_illegal(w_illegal)
  );

  assign cmd_ready  = (r_st == ST_IDLE);
  assign busy       = (r_st == ST_RUN);
  assign done       = (r_st == ST_DONE);
  assign aborted    = (r_st == ST_DONE) && r_abt;
  assign step_pulse = r_pulse;
  assign err        = r_err;

endmodule

// File: tb/tb_johnson_step_controller.sv
// Randomized bench for johnson_step_controller against a
// cycle-timeline reference model built from the command rules.
module tb_johnson_step_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_steps = '0;
  logic       cmd_dir = 1'b0;
  logic [7:0] cmd_period = '0;
  logic       abort = 1'b0;
  logic [3:0] phase;
  logic       step_pulse;
  logic       busy;
  logic       done;
  logic       aborted;
  logic       err;

  int n_chk = 0;
  int n_bad = 0;

  logic [3:0] m_ph  = 4'b1000;
  bit         m_err = 1'b0;

  localparam logic [3:0] HOME = 4'b1000;
  localparam logic [3:0] SEQ [8] = '{
    4'b1000, 4'b1100, 4'b1110, 4'b1111,
    4'b0111, 4'b0011, 4'b0001, 4'b0000
  };

  johnson_step_controller #(
    .WIDTH(4), .CNT_W(8), .DIV_W(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_steps (cmd_steps),
    .cmd_dir   (cmd_dir),
    .cmd_period(cmd_period),
    .abort     (abort),
    .phase     (phase),
    .step_pulse(step_pulse),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  // Next pattern by position in the listed forward sequence.
  function automatic logic [3:0] nxt(
    input  logic [3:0] q,
    input  bit         d,
    output bit         bad
  );
    logic [3:0] r;
    r   = HOME;
    bad = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (SEQ[i] == q) begin
        bad = 1'b0;
        r   = d ? SEQ[(i + 1) % 8] : SEQ[(i + 7) % 8];
      end
    end
    return r;
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_rdy"}, cmd_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_abt"}, aborted, 0);
    chk({tag, "_sp"}, step_pulse, 0);
    chk({tag, "_ph"}, phase, m_ph);
    chk({tag, "_err"}, err, m_err);
  endtask

  // Entered just after a negedge; leaves one negedge after
  // cmd_ready has returned. a = abort edge offset, 0 = none.
  task automatic run_cmd(
    input int n, input bit d, input int p, input int a
  );
    int  pp, e;
    bit  st, bad;
    pp = p + 1;
    e  = (a > 0) ? a : n * pp;
    chk("rdy_pre", cmd_ready, 1);
    cmd_valid  = 1'b1;
    cmd_steps  = 8'(n);
    cmd_dir    = d;
    cmd_period = 8'(p);
    abort      = 1'b0;
    m_err      = 1'b0;
    for (int t = 0; t <= e + 1; t++) begin
      @(negedge clk);
      st = (t > 0) && (t <= e) && (t % pp == 0)
           && (a == 0 || t < a);
      if (st) begin
        m_ph = nxt(m_ph, d, bad);
        if (bad) m_err = 1'b1;
      end
      chk("phase", phase, m_ph);
      chk("step_pulse", step_pulse, st);
      chk("busy", busy, t < e);
      chk("done", done, t == e);
      chk("aborted", aborted, (t == e) && (a > 0));
      chk("cmd_ready", cmd_ready, t > e);
      chk("err", err, m_err);
      if (t < e) begin
        cmd_valid  = 1'($urandom_range(0, 1));
        cmd_steps  = 8'($urandom);
        cmd_dir    = 1'($urandom_range(0, 1));
        cmd_period = 8'($urandom);
      end else begin
        cmd_valid = 1'b0;
      end
      abort = (a > 0 && t + 1 == a) ||
              (t == e && $urandom_range(0, 1) == 1);
    end
    abort = 1'b0;
  endtask

  task automatic idle_gap(input int k);
    for (int i = 0; i < k; i++) begin
      abort = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk_idle("gap");
    end
    abort = 1'b0;
  endtask

  initial begin
    int n, p, a;
    bit d;
    @(negedge clk);
    @(negedge clk);
    chk_idle("reset");
    rst = 1'b1;
    idle_gap(2);

    run_cmd(8, 1'b1, 0, 0);
    chk("fwd8_ph", phase, 4'b1000);
    run_cmd(3, 1'b0, 2, 0);
    chk("rev3_ph", phase, 4'b0011);
    run_cmd(5, 1'b1, 3, 8);
    idle_gap(1);
    run_cmd(0, 1'b1, 5, 0);

    force dut.u_ph.r_q = 4'b0101;
    @(negedge clk);
    release dut.u_ph.r_q;
    m_ph = 4'b0101;
    @(negedge clk);
    chk("deposit_ph", phase, 4'b0101);
    run_cmd(1, 1'b1, 0, 0);
    chk("illegal_err", err, 1);
    chk("illegal_ph", phase, HOME);
    run_cmd(2, 1'b0, 1, 0);

    cmd_valid  = 1'b1;
    cmd_steps  = 8'd5;
    cmd_dir    = 1'b1;
    cmd_period = 8'd3;
    repeat (4) @(negedge clk);
    chk("mid_busy", busy, 1);
    rst        = 1'b0;
    cmd_steps  = 8'd4;
    cmd_dir    = 1'b0;
    cmd_period = 8'd1;
    @(negedge clk);
    m_ph  = HOME;
    m_err = 1'b0;
    chk_idle("midrst");
    rst = 1'b1;
    run_cmd(4, 1'b0, 1, 0);

    for (int k = 0; k < 60; k++) begin
      n = $urandom_range(0, 10);
      p = $urandom_range(0, 4);
      d = 1'($urandom_range(0, 1));
      a = 0;
      if (n > 0 && $urandom_range(0, 3) == 0)
        a = $urandom_range(1, n * (p + 1));
      run_cmd(n, d, p, a);
      idle_gap($urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/johnson_step_controller.md
# johnson_step_controller

Command-driven sequencer for a 4-phase twisted-ring (Johnson) phase register. Each accepted command names a step count, a direction and a step period. The block advances the phase pattern by that many positions at the programmed rate, then reports completion. It sits between a host or stepper-drive FSM and the phase outputs that drive coil or multi-phase clock-enable logic. It owns all sequencing, abort handling and illegal-pattern recovery.

## Interface
- `WIDTH`, 4: phase register width; sequence length is 2*WIDTH.
- `CNT_W`, 8: step-count width.
- `DIV_W`, 8: step-period width.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst` input 1: reset, synchronous and active-low; clears all state on a rising `clk` edge while low.
- `cmd_valid` input 1: command offered.
- `cmd_ready` output 1: high only in IDLE; a command is accepted on an edge where `cmd_valid && cmd_ready`.
- `cmd_steps` input CNT_W: number of phase advances.
- `cmd_dir` input 1: 1 = forward, 0 = reverse.
- `cmd_period` input DIV_W: step interval is `cmd_period + 1` cycles.
- `abort` input 1: stop the running command.
- `phase` output WIDTH: Johnson phase pattern.
- `step_pulse` output 1: one-cycle pulse, high in the first cycle a new `phase` is visible.
- `busy` output 1: high in RUN.
- `done` output 1: one-cycle completion pulse.
- `aborted` output 1: qualifies `done`; high together with `done` when the command was aborted.
- `err` output 1: sticky; set when an illegal pattern is recovered; cleared on the next command acceptance.

## Operation
- Reset values:
  - `phase` = 1000 (MSB set, rest clear).
  - `cmd_ready` = 1; `busy`, `done`, `aborted`, `step_pulse`, `err` = 0.
  - State = IDLE.
- Forward sequence (shift right, MSB ← ~LSB): 1000 → 1100 → 1110 → 1111 → 0111 → 0011 → 0001 → 0000 → 1000.
- Reverse sequence (shift left, LSB ← ~MSB) is the exact inverse, e.g. 1000 → 0000 → 0001.
- Legal patterns are `1…10…0` and `0…01…1` (2*WIDTH codes). Any other pattern on a step edge:
  - `phase` loads 1000 instead of advancing;
  - `err` sets;
  - the step still counts.
- FSM states:
  - IDLE: on accept, latch steps, dir and period; divider ← period; remaining ← steps. Go to RUN, or to DONE if steps = 0.
  - RUN: divider decrements every cycle. When divider = 0:
    - advance `phase` and decrement remaining;
    - reload divider ← period;
    - if remaining becomes 0, go to DONE.
  - DONE: `done` = 1 for exactly one cycle, then return to IDLE.
- Abort: in RUN, `abort` forces DONE on the next edge with `aborted` = 1. `phase` holds its current value, and no step occurs on that edge even if divider = 0.
- `abort` in IDLE or DONE is ignored.
- `cmd_valid` while not in IDLE is ignored; the command is not accepted and must be held by the source.
- Latched command fields are immune to input changes after acceptance.

## Timing
- Accept at edge T. The k-th step is registered at edge T + k*(P+1), where P = latched period.
- `step_pulse` is high during the cycle after each step edge.
- After the last step edge (T + N*(P+1)):
  - `busy` falls at that edge;
  - `done` is high for the following cycle;
  - `cmd_ready` returns one edge later.
- Minimum command-to-command spacing: N*(P+1) + 2 cycles.
- steps = 0: `done` is high in the cycle after T; `phase` is unchanged; `busy` never asserts.
- P = 0: one step per cycle; `step_pulse` is high continuously for N cycles.
- Counter widths never wrap: remaining stops at 0; the divider reloads only on a step edge.
- Reset low mid-RUN: the next edge restores all reset values, and no `done` pulse is generated.

## Structure
- Shared package holds:
  - FSM state encoding: IDLE, RUN, DONE;
  - the HOME phase constant (1000 pattern generated from WIDTH);
  - the direction encoding constants.
- Sub-module `johnson_phase_reg`:
  - WIDTH-bit twisted-ring register with enable, direction, legality check and home reload;
  - outputs a `illegal` flag;
  - independently testable.
- Top level contains the FSM, the step-period divider and the remaining-steps counter.

## Test plan
- Reset, then forward command steps = 8, period = 0 → `phase` walks 1100, 1110, 1111, 0111, 0011, 0001, 0000, 1000; 8 `step_pulse` cycles; `done` at cycle 9 after accept.
- Reverse command steps = 3, period = 2 from 1000 → `phase` = 0000, 0001, 0011 at edges T+3, T+6, T+9; `done` high after T+9.
- `abort` asserted 1 cycle before the 2nd step edge (steps = 5, period = 3) → `phase` holds after 1 step; `done` and `aborted` high together; `cmd_ready` high 2 cycles later.
- steps = 0 → `done` in the cycle after accept; `busy` stays 0; `phase` unchanged.
- Force `phase` to 0101 (hierarchical deposit), then issue a 1-step command → `phase` = 1000 and `err` = 1; the next accept clears `err`.
- `rst` low mid-RUN with `cmd_valid` held high → reset values restored, no `done`; the command is accepted the first cycle after `rst` returns high.
